microcode_sequencer: RTL

//  Parametrised microprogram sequencer: next-generation control unit for the simple-viii core.

---
 rtl/microcode_sequencer_pkg.sv | 33 +++
 rtl/microcode_sequencer_if.sv | 43 ++++
 rtl/microcode_sequencer_store.sv | 30 +++
 rtl/microcode_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : microcode_sequencer_pkg
// Brief   : Shared control-word layout and default widths for the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package microcode_sequencer_pkg;

  localparam int SEQ_NEXT = 0;
  localparam int SEQ_LOAD = 1;
  localparam int SEQ_HALT = 2;
  localparam int SEQ_SRST = 3;
  localparam int SEQ_BITS = 4;

  localparam int DEF_STEP_W = 4;
  localparam int DEF_IR_W   = 8;
  localparam int DEF_FLAG_W = 2;
  localparam int DEF_CW_W   = 24;

  // Field order mirrors the bit indices above (MSB first).
  typedef struct packed {
    logic soft_reset;
    logic halt;
    logic load;
    logic next_instr;
  } seq_bits_t;

  function automatic seq_bits_t to_seq_bits(input logic [SEQ_BITS-1:0] raw);
    return seq_bits_t'(raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : microcode_sequencer_if
// Brief   : Datapath, flag, handshake and microcode-load signals of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface microcode_sequencer_if
  import microcode_sequencer_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int IR_W   = DEF_IR_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int CW_W   = DEF_CW_W
) ();

  localparam int ADDR_W = STEP_W + IR_W + FLAG_W;

  logic [IR_W-1:0]          bus;
  logic [FLAG_W-1:0]        flags;
  logic                     stall;
  logic                     resume;
  logic                     ucode_we;
  logic [ADDR_W-1:0]        ucode_addr;
  logic [CW_W-1:0]          ucode_wdata;
  logic                     ucode_ack;
  logic [CW_W-SEQ_BITS-1:0] dp_word;
  logic                     halted;
  logic                     fault;
  logic [STEP_W-1:0]        step;
  logic [IR_W-1:0]          ir;

  modport master (
    output bus, flags, stall, resume, ucode_we, ucode_addr, ucode_wdata,
    input  ucode_ack, dp_word, halted, fault, step, ir
  );

  modport slave (
    input  bus, flags, stall, resume, ucode_we, ucode_addr, ucode_wdata,
    output ucode_ack, dp_word, halted, fault, step, ir
  );

endinterface
`default_nettype wire

// File: rtl/microcode_sequencer_store.sv
`default_nettype none
// ============================================================================
// Module  : microcode_store
// Brief   : Writable microcode RAM, asynchronous read, no reset on contents.
// Revision: 1.0 - initial release
// ============================================================================
module microcode_store #(
  parameter int ADDR_W = 14,
  parameter int CW_W   = 24
) (
  input  wire logic              clock,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [CW_W-1:0]   wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [CW_W-1:0]   rdata
);

  logic [CW_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : microcode_sequencer
// Brief   : Microprogram sequencer indexing a writable store with {step, ir, flags}.
// Revision: 1.0 - initial release
// ============================================================================
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int IR_W   = DEF_IR_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int CW_W   = DEF_CW_W
) (
  input wire logic              clock,
  input wire logic              reset,
  microcode_sequencer_if.slave  bus_if
);

  localparam int ADDR_W = STEP_W + IR_W + FLAG_W;

  logic [STEP_W-1:0] step_q,   step_d;
  logic [IR_W-1:0]   ir_q,     ir_d;
  logic [FLAG_W-1:0] flags_q,  flags_d;
  logic              halted_q, halted_d;
  logic              fault_q,  fault_d;
  logic              ack_q,    ack_d;

  logic [ADDR_W-1:0] w_raddr;
  logic [CW_W-1:0]   w_cw;
  seq_bits_t         w_seq;
  logic              w_advance;
  logic              w_write_en;

  assign w_raddr    = {step_q, ir_q, flags_q};
  assign w_seq      = to_seq_bits(w_cw[SEQ_BITS-1:0]);
  assign w_advance  = !halted_q && !fault_q && !bus_if.stall;
  // Reset gates the store write because the RAM itself has no reset.
  assign w_write_en = bus_if.ucode_we && (halted_q || fault_q) && !reset;

  microcode_store #(
    .ADDR_W (ADDR_W),
    .CW_W   (CW_W)
  ) u_store (
    .clock (clock),
    .we    (w_write_en),
    .waddr (bus_if.ucode_addr),
    .wdata (bus_if.ucode_wdata),
    .raddr (w_raddr),
    .rdata (w_cw)
  );

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    ack_d    = w_write_en;

    if (w_advance) begin
      flags_d = bus_if.flags;
      if (w_seq.load) begin
        ir_d = bus_if.bus;
      end
      if (w_seq.halt) begin
        halted_d = 1'b1;
      end
      if (w_seq.soft_reset) begin
        step_d  = '0;
        ir_d    = '0;
        flags_d = '0;
      end else if (w_seq.next_instr) begin
        step_d = '0;
      end else if (step_q == {STEP_W{1'b1}}) begin
        fault_d = 1'b1;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end else if (halted_q && !fault_q && !bus_if.stall && bus_if.resume) begin
      // The step already moved past the halt word, so resume only clears halted.
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q   <= '0;
      ir_q     <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      ir_q     <= ir_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      ack_q    <= ack_d;
    end
  end

  assign bus_if.dp_word   = (halted_q || fault_q) ? '0 : w_cw[CW_W-1:SEQ_BITS];
  assign bus_if.ucode_ack = ack_q;
  assign bus_if.halted    = halted_q;
  assign bus_if.fault     = fault_q;
  assign bus_if.step      = step_q;
  assign bus_if.ir        = ir_q;

endmodule
`default_nettype wire
